// File: rtl/pll_seq_pkg.sv
// Shared types and default timing for the CPU PLL reset sequencer.
// Defaults assume the 100 MHz free-running board clock.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STRETCH   = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam int RELOCK_W = 8;

  localparam int BOARD_HZ = 100_000_000;

  localparam int DEF_RST_CYCLES     = BOARD_HZ / 1_000_000;
  localparam int DEF_LOCK_TIMEOUT   = BOARD_HZ / 1_000;
  localparam int DEF_STRETCH_CYCLES = 1000;
  localparam int DEF_MAX_RETRIES    = 4;
  localparam int DEF_CNT_W          = 20;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cdc_sync2.sv
// Two-flop synchronizer for asynchronous status inputs.
// Synchronous active-low reset clears both stages.
module cdc_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the CPU PLL reset, waits for lock with timeout/retry,
// stretches SoC reset until lock is stable, re-sequences on loss.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES     = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                clkin,
  input  logic                reset_n,
  input  logic                pll_locked,
  input  logic                retry,
  output logic                pll_reset,
  output logic                sys_reset_n,
  output logic                ready,
  output logic                fault,
  output logic [RELOCK_W-1:0] relock_cnt
);

  localparam int RW =
    (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;
  localparam int CMAX =
    max3(RST_CYCLES, LOCK_TIMEOUT, STRETCH_CYCLES);

  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STR_LAST =
    CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [RW-1:0] TRY_LAST =
    RW'(MAX_RETRIES - 1);

  if (CNT_W < 31 && CMAX > (1 << CNT_W)) begin : g_cnt_chk
    $error("CNT_W too narrow for timing parameters");
  end

  if (RST_CYCLES < 1 || LOCK_TIMEOUT < 1 ||
      STRETCH_CYCLES < 1 || MAX_RETRIES < 1) begin : g_par_chk
    $error("timing parameters must be at least 1");
  end

  logic                lock_s;
  state_t              state;
  state_t              state_nx;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nx;
  logic [RW-1:0]       tries;
  logic [RW-1:0]       tries_nx;
  logic [RELOCK_W-1:0] relock_nx;

  cdc_sync2 #(
    .WIDTH(1)
  ) u_lock_sync (
    .clk  (clkin),
    .rst_n(reset_n),
    .d    (pll_locked),
    .q    (lock_s)
  );

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt + 1'b1;
    tries_nx  = tries;
    relock_nx = relock_cnt;
    unique case (state)
      RESET_PLL: begin
        if (cnt == RST_LAST) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nx = STRETCH;
          cnt_nx   = '0;
        end else if (cnt == TO_LAST) begin
          cnt_nx = '0;
          if (tries == TRY_LAST) begin
            state_nx = FAULT;
          end else begin
            state_nx = RESET_PLL;
            tries_nx = tries + 1'b1;
          end
        end
      end
      STRETCH: begin
        if (!lock_s) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end else if (cnt == STR_LAST) begin
          state_nx = RUN;
          cnt_nx   = '0;
          tries_nx = '0;
        end
      end
      RUN: begin
        cnt_nx = '0;
        if (!lock_s) begin
          state_nx = RESET_PLL;
          if (relock_cnt != '1) begin
            relock_nx = relock_cnt + 1'b1;
          end
        end
      end
      FAULT: begin
        cnt_nx = '0;
        if (retry) begin
          state_nx = RESET_PLL;
          tries_nx = '0;
        end
      end
      default: begin
        state_nx = RESET_PLL;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs decode the next state so they change on the
  // same edge as the transition that causes them.
  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      state       <= RESET_PLL;
      cnt         <= '0;
      tries       <= '0;
      relock_cnt  <= '0;
      pll_reset   <= 1'b1;
      sys_reset_n <= 1'b0;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      tries       <= tries_nx;
      relock_cnt  <= relock_nx;
      pll_reset   <= (state_nx == RESET_PLL) ||
                     (state_nx == FAULT);
      sys_reset_n <= (state_nx == RUN);
      ready       <= (state_nx == RUN);
      fault       <= (state_nx == FAULT);
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: per-cycle phase/countdown model
// plus directed bring-up, glitch, timeout, fault, loss and reset.
module tb_pll_reset_sequencer;

  localparam int RST = 4;
  localparam int TMO = 20;
  localparam int STR = 8;
  localparam int MAXR = 2;

  localparam int M_RST = 0;
  localparam int M_WAIT = 1;
  localparam int M_STR = 2;
  localparam int M_RUN = 3;
  localparam int M_FLT = 4;

  logic       clkin;
  logic       reset_n;
  logic       pll_locked;
  logic       retry;
  logic       pll_reset;
  logic       sys_reset_n;
  logic       ready;
  logic       fault;
  logic [7:0] relock_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  pll_reset_sequencer #(
    .RST_CYCLES    (RST),
    .LOCK_TIMEOUT  (TMO),
    .STRETCH_CYCLES(STR),
    .MAX_RETRIES   (MAXR),
    .CNT_W         (8)
  ) dut (
    .clkin      (clkin),
    .reset_n    (reset_n),
    .pll_locked (pll_locked),
    .retry      (retry),
    .pll_reset  (pll_reset),
    .sys_reset_n(sys_reset_n),
    .ready      (ready),
    .fault      (fault),
    .relock_cnt (relock_cnt)
  );

  initial begin
    clkin = 1'b0;
    forever #5 clkin = ~clkin;
  end

  // Model: phase plus cycles left in it; lock seen 2 edges late.
  int   ph = M_RST;
  int   left = RST;
  int   fails = 0;
  int   relock = 0;
  logic s1 = 1'b0;
  logic s2 = 1'b0;

  always @(posedge clkin) begin
    logic ls;
    logic [11:0] exp_v;
    logic [11:0] got_v;
    cyc++;
    if (!reset_n) begin
      ph = M_RST; left = RST; fails = 0;
      relock = 0; s1 = 1'b0; s2 = 1'b0;
    end else begin
      ls = s2; s2 = s1; s1 = pll_locked;
      case (ph)
        M_RST: begin
          left--;
          if (left == 0) begin ph = M_WAIT; left = TMO; end
        end
        M_WAIT: begin
          if (ls) begin
            ph = M_STR; left = STR;
          end else begin
            left--;
            if (left == 0) begin
              fails++;
              if (fails == MAXR) ph = M_FLT;
              else begin ph = M_RST; left = RST; end
            end
          end
        end
        M_STR: begin
          if (!ls) begin
            ph = M_WAIT; left = TMO;
          end else begin
            left--;
            if (left == 0) begin ph = M_RUN; fails = 0; end
          end
        end
        M_RUN: begin
          if (!ls) begin
            if (relock < 255) relock++;
            ph = M_RST; left = RST;
          end
        end
        default: begin
          if (retry) begin
            ph = M_RST; left = RST; fails = 0;
          end
        end
      endcase
    end
    exp_v = {(ph == M_RST || ph == M_FLT), (ph == M_RUN),
             (ph == M_RUN), (ph == M_FLT), 8'(relock)};
    #1;
    got_v = {pll_reset, sys_reset_n, ready, fault, relock_cnt};
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL model cyc %0d: got %h expected %h",
               cyc, got_v, exp_v);
    end
  end

  task automatic check(input string name, input int act,
                       input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic outsel(input int sel);
    case (sel)
      0: return pll_reset;
      1: return sys_reset_n;
      2: return ready;
      default: return fault;
    endcase
  endfunction

  task automatic wait_out(input int sel, input logic val,
                          input int lim, output int n);
    n = 0;
    do begin
      @(negedge clkin);
      n++;
    end while (outsel(sel) !== val && n < lim);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clkin);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; pll_locked = 1'b0; retry = 1'b0;
    tick(3);
    check("rst pll_reset", pll_reset, 1);
    check("rst sys_reset_n", sys_reset_n, 0);
    check("rst ready", ready, 0);
    check("rst fault", fault, 0);

    reset_n = 1'b1;
    wait_out(0, 1'b0, 50, n);
    check("bringup pll_reset width", n, 4);
    tick(2);
    pll_locked = 1'b1;
    wait_out(1, 1'b1, 50, n);
    check("bringup latency", n, 11);
    check("bringup ready", ready, 1);
    check("bringup relock", relock_cnt, 0);

    pll_locked = 1'b0;
    wait_out(1, 1'b0, 50, n);
    check("loss latency", n, 3);
    check("loss ready", ready, 0);
    check("loss relock", relock_cnt, 1);
    wait_out(0, 1'b0, 50, n);
    check("loss pll_reset width", n, 4);

    pll_locked = 1'b1;
    tick(6);
    pll_locked = 1'b0;
    tick(1);
    check("glitch sys_reset_n", sys_reset_n, 0);
    pll_locked = 1'b1;
    wait_out(2, 1'b1, 50, n);
    check("glitch relatency", n, 11);

    pll_locked = 1'b0;
    wait_out(1, 1'b0, 50, n);
    wait_out(0, 1'b0, 50, n);
    wait_out(0, 1'b1, 50, n);
    check("timeout length", n, 20);
    wait_out(0, 1'b0, 50, n);
    check("timeout repulse", n, 4);
    pll_locked = 1'b1;
    wait_out(2, 1'b1, 50, n);
    check("attempt2 latency", n, 11);

    pll_locked = 1'b0;
    wait_out(1, 1'b0, 50, n);
    wait_out(0, 1'b0, 50, n);
    wait_out(0, 1'b1, 50, n);
    wait_out(0, 1'b0, 50, n);
    wait_out(3, 1'b1, 50, n);
    check("fault after 2 timeouts", n, 20);
    tick(10);
    check("fault held", fault, 1);
    check("fault pll_reset", pll_reset, 1);
    retry = 1'b1;
    tick(1);
    retry = 1'b0;
    check("retry clears fault", fault, 0);
    check("retry pll_reset", pll_reset, 1);
    wait_out(0, 1'b0, 50, n);
    check("retry pll_reset width", n, 4);
    pll_locked = 1'b1;
    wait_out(2, 1'b1, 50, n);
    check("post-fault latency", n, 11);
    retry = 1'b1;
    tick(1);
    retry = 1'b0;
    tick(3);
    check("retry in RUN ready", ready, 1);
    check("retry in RUN fault", fault, 0);
    check("relock before loop", relock_cnt, 3);

    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      wait_out(2, 1'b0, 50, n);
      pll_locked = 1'b1;
      wait_out(2, 1'b1, 50, n);
    end
    check("relock saturated", relock_cnt, 255);

    pll_locked = 1'b0;
    wait_out(1, 1'b0, 50, n);
    wait_out(0, 1'b0, 50, n);
    pll_locked = 1'b1;
    tick(6);
    reset_n = 1'b0;
    tick(1);
    check("midrst pll_reset", pll_reset, 1);
    check("midrst sys_reset_n", sys_reset_n, 0);
    check("midrst ready", ready, 0);
    check("midrst fault", fault, 0);
    check("midrst relock", relock_cnt, 0);
    tick(2);
    reset_n = 1'b1;
    wait_out(0, 1'b0, 50, n);
    check("midrst pll_reset width", n, 4);
    wait_out(2, 1'b1, 50, n);
    check("midrst rerun", n, 9);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares + 1);
    $fatal(1);
  end

endmodule
